led_bar_decoder: RTL and testbench

// - Reverse path of the LED bar display: samples a 16-bit thermometer-coded bar (switch bank / bar readback),

---
 rtl/led_bar_pkg.sv | 14 +
 rtl/led_bar_decoder_if.sv | 36 +++
 rtl/led_bar_tick_gen.sv | 26 ++
 rtl/led_bar_decoder.sv | 128 ++++++++++++
 tb/tb_led_bar_decoder.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/led_bar_pkg.sv
// Shared constants and FSM encoding for the LED bar readback path.
package led_bar_pkg;

  localparam int unsigned BAR_W   = 16;
  localparam int unsigned LVL_W   = 5;
  localparam int unsigned LVL_MAX = 16;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StTrack  = 2'd1,
    StCommit = 2'd2
  } state_e;

endpackage

// File: rtl/led_bar_decoder_if.sv
// Bundle between board-side bar inputs and the decoder: sample control, raw bar, decoded level.
interface led_bar_decoder_if;
  import led_bar_pkg::*;

  logic             en;
  logic [BAR_W-1:0] therm_in;
  logic [LVL_W-1:0] count_out;
  logic             up_down;
  logic             changed;
  logic             err;
  logic             at_max;
  logic             at_min;

  modport master (
    output en,
    output therm_in,
    input  count_out,
    input  up_down,
    input  changed,
    input  err,
    input  at_max,
    input  at_min
  );

  modport slave (
    input  en,
    input  therm_in,
    output count_out,
    output up_down,
    output changed,
    output err,
    output at_max,
    output at_min
  );

endinterface

// File: rtl/led_bar_tick_gen.sv
// Sample-rate divider: one-clk tick every DIV_CNT enabled clocks; frozen while en is low.
module led_bar_tick_gen #(
  parameter int unsigned DIV_CNT = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (DIV_CNT > 2) ? $clog2(DIV_CNT) : 1;
  localparam logic [CW-1:0] Last = CW'(DIV_CNT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == Last) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = en && (cnt_q == Last);

endmodule

// File: rtl/led_bar_decoder.sv
// Debounces a 16-bit thermometer bar and commits a 0..16 level with direction and error flags.
// Optional macro BUBBLE_CORRECT_EN: invalid codes are committed as their popcount (err still set).
module led_bar_decoder
  import led_bar_pkg::*;
#(
  parameter int unsigned DIV_CNT      = 50000,
  parameter int unsigned STABLE_TICKS = 3
) (
  input logic               clk,
  input logic               rst,
  led_bar_decoder_if.slave  bar
);

  localparam int unsigned SW = $clog2(STABLE_TICKS + 1);
  localparam logic [SW-1:0] StabMax = SW'(STABLE_TICKS);

  // Thermometer code is all ones below some bit: v & (v+1) clears to zero.
  function automatic logic therm_valid(input logic [BAR_W-1:0] v);
    logic [BAR_W-1:0] inc;
    inc = v + 1'b1;
    return (v & inc) == '0;
  endfunction

  function automatic logic [LVL_W-1:0] popcount(input logic [BAR_W-1:0] v);
    logic [LVL_W-1:0] s;
    s = '0;
    for (int i = 0; i < BAR_W; i++) begin
      s = s + LVL_W'(v[i]);
    end
    return s;
  endfunction

  state_e           state_q;
  logic [BAR_W-1:0] sync1_q, sync_q, cand_q;
  logic [SW-1:0]    stab_q, stab_nxt;
  logic             done_q;
  logic             new_cand, commit_go, tick;
  logic [LVL_W-1:0] count_q, lvl;
  logic             up_q, changed_q, err_q, valid, apply;

  led_bar_tick_gen #(
    .DIV_CNT(DIV_CNT)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (bar.en),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync_q  <= '0;
    end else begin
      sync1_q <= bar.therm_in;
      sync_q  <= sync1_q;
    end
  end

  always_comb begin
    new_cand = (sync_q != cand_q);
    stab_nxt = stab_q;
    if (new_cand) begin
      stab_nxt = SW'(1);
    end else if (stab_q < StabMax) begin
      stab_nxt = stab_q + 1'b1;
    end
    // done_q blocks a second commit of the same candidate once saturated.
    commit_go = tick && (stab_nxt == StabMax) && (new_cand || !done_q);
  end

  always_comb begin
    lvl   = popcount(cand_q);
    valid = therm_valid(cand_q);
`ifdef BUBBLE_CORRECT_EN
    apply = 1'b1;
`else
    apply = valid;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cand_q    <= '0;
      stab_q    <= '0;
      done_q    <= 1'b0;
      count_q   <= '0;
      up_q      <= 1'b1;
      changed_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      changed_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bar.en) state_q <= StTrack;
        end
        StTrack: begin
          if (tick) begin
            cand_q <= sync_q;
            stab_q <= stab_nxt;
            if (new_cand) done_q <= 1'b0;
            if (commit_go) state_q <= StCommit;
          end
        end
        StCommit: begin
          done_q  <= 1'b1;
          err_q   <= !valid;
          state_q <= StTrack;
          if (apply && (lvl != count_q)) begin
            count_q   <= lvl;
            up_q      <= (lvl > count_q);
            changed_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bar.count_out = count_q;
  assign bar.up_down   = up_q;
  assign bar.changed   = changed_q;
  assign bar.err       = err_q;
  assign bar.at_max    = (count_q == LVL_W'(LVL_MAX));
  assign bar.at_min    = (count_q == '0);

endmodule

// File: tb/tb_led_bar_decoder.sv
// Directed bench for led_bar_decoder (DIV_CNT=4, STABLE_TICKS=3); honours BUBBLE_CORRECT_EN.
module tb_led_bar_decoder;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  int   pulses = 0;
  int   double_pulses = 0;
  logic prev_changed = 1'b0;
  int   p0;
  int   lat;

`ifdef BUBBLE_CORRECT_EN
  localparam logic [31:0] BubLvl = 32'd7;
  localparam logic [31:0] BubPulses = 32'd1;
`else
  localparam logic [31:0] BubLvl = 32'd8;
  localparam logic [31:0] BubPulses = 32'd0;
`endif

  led_bar_decoder_if bar ();

  led_bar_decoder #(
    .DIV_CNT      (4),
    .STABLE_TICKS (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bar (bar)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bar.changed === 1'b1) pulses++;
    if (bar.changed === 1'b1 && prev_changed === 1'b1) double_pulses++;
    prev_changed = bar.changed;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"}, 32'(bar.count_out), 32'd0);
    check({tag, "_up"}, 32'(bar.up_down), 32'd1);
    check({tag, "_changed"}, 32'(bar.changed), 32'd0);
    check({tag, "_err"}, 32'(bar.err), 32'd0);
    check({tag, "_at_min"}, 32'(bar.at_min), 32'd1);
    check({tag, "_at_max"}, 32'(bar.at_max), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bar.en = 1'b0;
    bar.therm_in = 16'h00FF;
    step(3);
    check_reset_outputs("rst");

    // Power-up commit to level 8.
    rst = 1'b0;
    bar.en = 1'b1;
    p0 = pulses;
    step(40);
    check("init_count", 32'(bar.count_out), 32'd8);
    check("init_up", 32'(bar.up_down), 32'd1);
    check("init_err", 32'(bar.err), 32'd0);
    check("init_pulses", 32'(pulses - p0), 32'd1);

    // Step down to 4; pulse expected 12..15 edges after the change.
    bar.therm_in = 16'h000F;
    p0 = pulses;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (bar.changed === 1'b1 && lat == 0) lat = n;
    end
    check("down_count", 32'(bar.count_out), 32'd4);
    check("down_up", 32'(bar.up_down), 32'd0);
    check("down_pulses", 32'(pulses - p0), 32'd1);
    check("down_lat_min", 32'(lat >= 12), 32'd1);
    check("down_lat_max", 32'(lat <= 15), 32'd1);
    check("down_at_min", 32'(bar.at_min), 32'd0);

    // Full bar.
    bar.therm_in = 16'hFFFF;
    step(40);
    check("full_count", 32'(bar.count_out), 32'd16);
    check("full_at_max", 32'(bar.at_max), 32'd1);
    check("full_up", 32'(bar.up_down), 32'd1);
    check("full_err", 32'(bar.err), 32'd0);

    // Back to 8, then a one-tick glitch must not commit.
    bar.therm_in = 16'h00FF;
    step(40);
    check("back8_count", 32'(bar.count_out), 32'd8);
    p0 = pulses;
    bar.therm_in = 16'h01FF;
    step(4);
    bar.therm_in = 16'h00FF;
    step(40);
    check("glitch_pulses", 32'(pulses - p0), 32'd0);
    check("glitch_count", 32'(bar.count_out), 32'd8);

    // Bubble code.
    p0 = pulses;
    bar.therm_in = 16'h00F7;
    step(40);
    check("bubble_err", 32'(bar.err), 32'd1);
    check("bubble_count", 32'(bar.count_out), BubLvl);
    check("bubble_pulses", 32'(pulses - p0), BubPulses);
`ifdef BUBBLE_CORRECT_EN
    check("bubble_up", 32'(bar.up_down), 32'd0);
`endif

    // en low mid-filter freezes everything, err kept.
    p0 = pulses;
    bar.therm_in = 16'h0003;
    step(6);
    bar.en = 1'b0;
    step(20);
    check("enlo_pulses", 32'(pulses - p0), 32'd0);
    check("enlo_count", 32'(bar.count_out), BubLvl);
    check("enlo_err", 32'(bar.err), 32'd1);
    bar.en = 1'b1;
    step(40);
    check("enhi_count", 32'(bar.count_out), 32'd2);
    check("enhi_pulses", 32'(pulses - p0), 32'd1);
    check("enhi_err", 32'(bar.err), 32'd0);
    check("enhi_up", 32'(bar.up_down), 32'd0);

    // Reset mid-filter: outputs clear without waiting for a clock.
    bar.therm_in = 16'h0000;
    step(6);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    step(2);
    rst = 1'b0;
    p0 = pulses;
    step(40);
    check("post_rst_pulses", 32'(pulses - p0), 32'd0);
    check("post_rst_count", 32'(bar.count_out), 32'd0);
    check("post_rst_at_min", 32'(bar.at_min), 32'd1);
    check("post_rst_err", 32'(bar.err), 32'd0);

    check("no_double_pulse", 32'(double_pulses), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
